cnn_mac_engine: RTL

- Dot-product coprocessor that sits directly downstream of weight_memory and beside the EX stage.
- A custom CNN instruction in EX pulses start with a weight base address, an activation base address and a length.
- The engine streams weights from weight_memory and activations from the data-memory second read port, then multiply-accumulates, scales, saturates and optionally applies ReLU.
- It returns one 32-bit result for write-back and requests a pipeline stall while running.

---
 rtl/cnn_mac_engine.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cnn_mac_engine.sv
// ============================================================================
// Module   : cnn_mac_engine
// Brief    : Streaming signed dot-product engine with scale, saturate and ReLU.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cnn_mac_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int ACC_WIDTH  = 64,
    parameter int FRAC_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] w_base,
    input  logic [ADDR_WIDTH-1:0] a_base,
    input  logic [ADDR_WIDTH-1:0] len,
    input  logic                  relu_en,
    output logic [ADDR_WIDTH-1:0] weight_addr,
    input  logic [DATA_WIDTH-1:0] weight_data,
    output logic [ADDR_WIDTH-1:0] act_addr,
    input  logic [DATA_WIDTH-1:0] act_data,
    output logic                  busy,
    output logic                  stall_req,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] c_addr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_WIDTH-1:0] c_sat_max =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_sat_min =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]                   r_state;
    logic [ADDR_WIDTH-1:0]        r_w_base;
    logic [ADDR_WIDTH-1:0]        r_a_base;
    logic [ADDR_WIDTH-1:0]        r_len;
    logic                         r_relu;
    logic [ADDR_WIDTH-1:0]        r_k;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic                         r_mac_vld;
    logic [ADDR_WIDTH-1:0]        r_weight_addr;
    logic [ADDR_WIDTH-1:0]        r_act_addr;
    logic [DATA_WIDTH-1:0]        r_result;

    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    w_prod_ext;
    logic signed [ACC_WIDTH-1:0]    w_acc_sum;
    logic signed [ACC_WIDTH-1:0]    w_shifted;
    logic [DATA_WIDTH-1:0]          w_sat;
    logic [DATA_WIDTH-1:0]          w_result_fmt;
    logic [ADDR_WIDTH-1:0]          w_k_next;
    logic                           w_last;

    // Memory data arrives one cycle after its address, so the product is
    // valid in the cycle following each RUN cycle (r_mac_vld).
    assign w_prod     = $signed(weight_data) * $signed(act_data);
    assign w_prod_ext = ACC_WIDTH'(w_prod);
    assign w_acc_sum  = r_mac_vld ? (r_acc + w_prod_ext) : r_acc;
    assign w_shifted  = w_acc_sum >>> FRAC_BITS;

    always_comb begin
        w_sat = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted > c_sat_max) begin
            w_sat = c_sat_max[DATA_WIDTH-1:0];
        end else if (w_shifted < c_sat_min) begin
            w_sat = c_sat_min[DATA_WIDTH-1:0];
        end
        w_result_fmt = w_sat;
        if (r_relu && w_sat[DATA_WIDTH-1]) begin
            w_result_fmt = '0;
        end
    end

    assign w_k_next = r_k + c_addr_one;
    assign w_last   = (r_k == (r_len - c_addr_one));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_w_base      <= '0;
            r_a_base      <= '0;
            r_len         <= '0;
            r_relu        <= 1'b0;
            r_k           <= '0;
            r_acc         <= '0;
            r_mac_vld     <= 1'b0;
            r_weight_addr <= '0;
            r_act_addr    <= '0;
            r_result      <= '0;
        end else begin
            r_mac_vld <= (r_state == S_RUN);
            case (r_state)
                S_IDLE: begin
                    r_weight_addr <= '0;
                    r_act_addr    <= '0;
                    if (start) begin
                        r_w_base <= w_base;
                        r_a_base <= a_base;
                        r_len    <= len;
                        r_relu   <= relu_en;
                        r_acc    <= '0;
                        r_k      <= '0;
                        if (len != '0) begin
                            r_state       <= S_RUN;
                            r_weight_addr <= w_base;
                            r_act_addr    <= a_base;
                        end else begin
                            r_state  <= S_DONE;
                            r_result <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_sum;
                    if (w_last) begin
                        r_state       <= S_DRAIN;
                        r_weight_addr <= '0;
                        r_act_addr    <= '0;
                    end else begin
                        r_k           <= w_k_next;
                        r_weight_addr <= r_w_base + w_k_next;
                        r_act_addr    <= r_a_base + w_k_next;
                    end
                end
                S_DRAIN: begin
                    r_acc    <= w_acc_sum;
                    r_result <= w_result_fmt;
                    r_state  <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign weight_addr = r_weight_addr;
    assign act_addr    = r_act_addr;
    assign result      = r_result;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign stall_req   = ((r_state == S_IDLE) && start) || (r_state == S_RUN) ||
                         (r_state == S_DRAIN);

endmodule

`default_nettype wire
